// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU using a start/busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete in one cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_in,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [5:0]      LAST_IT  = 6'd31;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed & v[XLEN-1]) ? neg(v) : v;
    endfunction

    state_t          r_state;
    logic [1:0]      r_op;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd_orig;
    logic [5:0]      r_cnt;
    logic            r_qsign;
    logic            r_rsign;
    logic            r_dz;
    logic            r_ovf;

    logic            w_signed;
    logic            w_dz;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_fix_result;

    assign w_signed = ~i_op[0];
    assign w_dz     = (i_rs2 == ZERO);
    assign w_ovf    = w_signed & (i_rs1 == MIN_NEG) & (i_rs2 == ALL_ONES);

    // One restoring step: the shifted partial remainder needs XLEN+1 bits before the compare.
    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_ge       = (w_shift >= {1'b0, r_dvs});
        w_quo_next = {r_quo[XLEN-2:0], w_ge};
        if (w_ge) begin
            w_rem_next = w_shift[XLEN-1:0] - r_dvs;
        end else begin
            w_rem_next = w_shift[XLEN-1:0];
        end
    end

    // Sign correction with RISC-V special-case overrides taking priority.
    always_comb begin
        w_fix_result = ZERO;
        if (r_dz) begin
            w_fix_result = r_op[1] ? r_dvd_orig : ALL_ONES;
        end else if (r_ovf) begin
            w_fix_result = r_op[1] ? ZERO : MIN_NEG;
        end else if (r_op[1]) begin
            w_fix_result = (r_rsign & ~r_op[0]) ? neg(r_rem) : r_rem;
        end else begin
            w_fix_result = (r_qsign & ~r_op[0]) ? neg(r_quo) : r_quo;
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 2'd0;
            r_rd       <= 5'd0;
            r_dvs      <= ZERO;
            r_quo      <= ZERO;
            r_rem      <= ZERO;
            r_dvd_orig <= ZERO;
            r_cnt      <= 6'd0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= ZERO;
            o_rd_out   <= 5'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op       <= i_op;
                        r_rd       <= i_rd_in;
                        r_quo      <= mag(i_rs1, w_signed);
                        r_dvs      <= mag(i_rs2, w_signed);
                        r_dvd_orig <= i_rs1;
                        r_rem      <= ZERO;
                        r_cnt      <= 6'd0;
                        r_qsign    <= i_rs1[XLEN-1] ^ i_rs2[XLEN-1];
                        r_rsign    <= i_rs1[XLEN-1];
                        r_dz       <= w_dz;
                        r_ovf      <= w_ovf;
                        o_busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        r_state    <= (w_dz | w_ovf) ? ST_FIX : ST_CALC;
`else
                        r_state    <= ST_CALC;
`endif
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST_IT) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    o_result <= w_fix_result;
                    o_rd_out <= r_rd;
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a cycle-level behavioural reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SL = 1;
`else
    localparam int SL = 33;
`endif

    div_unit #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_rd_in  (rd_in),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_rd_out (rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return is_special(o, a, b) ? SL : 33;
    endfunction

    function automatic logic [31:0] ref_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        case (o)
            2'd0:    return 32'(sa / sb);
            2'd1:    return 32'(ua / ub);
            2'd2:    return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    logic        m_on = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_pres = 32'd0;
    logic [4:0]  m_prd = 5'd0;
    int          m_left = 0;

    // Reference: one request in flight, result appears after its latency in edges.
    always @(posedge clk) begin
        if (rst) begin
            m_on   <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
            m_rd   <= 5'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_left <= lat_of(op, rs1, rs2);
                m_pres <= ref_fn(op, rs1, rs2);
                m_prd  <= rd_in;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= m_pres;
                    m_rd   <= m_prd;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Cycle compare of all outputs against the reference.
    always @(negedge clk) begin
        if (m_on) begin
            checks++;
            if (busy !== m_busy || done !== m_done || result !== m_res || rd_out !== m_rd) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t busy=%b want %b done=%b want %b result=%h want %h rd=%0d want %0d",
                         $time, busy, m_busy, done, m_done, result, m_res, rd_out, m_rd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
        int c;
        op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
        wait_done(c);
        check({name, "_lat"}, 32'(c), 32'(exp_lat));
        check({name, "_res"}, result, exp_res);
        check({name, "_rd"}, 32'(rd_out), 32'(rd));
    endtask

    initial begin
        int c;
        int seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [4:0]  rr;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        rst = 1'b0;

        run("divu_100_7", 2'd1, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        run("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
        run("remu_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1, 33);
        run("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, SL);
        run("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, SL);
        run("div_dz", 2'd0, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, SL);
        run("divu_dz", 2'd1, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, SL);
        run("rem_dz", 2'd2, 32'd5, 32'd0, 5'd13, 32'd5, SL);
        run("remu_dz", 2'd3, 32'd5, 32'd0, 5'd14, 32'd5, SL);

        // Re-pulse start mid-operation with different operands.
        op = 2'd1; rs1 = 32'd1000; rs2 = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            if (c == 10) begin
                op = 2'd0; rs1 = 32'd50; rs2 = 32'd5; rd_in = 5'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        check("repulse_lat", 32'(c), 32'd33);
        check("repulse_res", result, 32'd142);
        check("repulse_rd", 32'(rd_out), 32'd3);
        @(posedge clk);
        #1;
        check("repulse_idle", 32'(busy), 32'd0);

        // Start held high through the done cycle chains a second op.
        op = 2'd1; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            if (c == 30) begin
                op = 2'd0; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; rd_in = 5'd2; start = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        check("b2b_a_lat", 32'(c), 32'd33);
        check("b2b_a_res", result, 32'd333);
        check("b2b_a_start_held", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_b_busy", 32'(busy), 32'd1);
        wait_done(c);
        check("b2b_b_lat", 32'(c), 32'd33);
        check("b2b_b_res", result, 32'hFFFF_FFF2);
        check("b2b_b_rd", 32'(rd_out), 32'd2);

        // Reset mid-operation aborts without a done pulse.
        op = 2'd1; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd", 32'(rd_out), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run("divu_after_abort", 2'd1, 32'd1000, 32'd3, 5'd6, 32'd333, 33);

        // Reset and start together: request dropped.
        rst = 1'b1; start = 1'b1; op = 2'd1; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy0", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("rst_start_busy1", 32'(busy), 32'd0);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            rr = 5'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run("rand", ro, ra, rb, rr, ref_fn(ro, ra, rb), lat_of(ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
